// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity, break detection
// and a small registered-output receive FIFO.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   input  logic                 os_tick,
   input  logic                 o_ready,
   input  logic                 i_clr_err,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_break,
   output logic [2:0]           fsm_state
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_BITS + 2;
   localparam logic [CW-1:0] SAMP0 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] SAMP1 = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] SAMP2 = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_RECOVER
   } state_t;

   state_t                 state;
   logic                   rst_meta, rst_sync;
   logic                   rx_meta, rx_sync, line_q;
   logic [CW-1:0]          cnt;
   logic [BW-1:0]          bit_idx;
   logic                   stop_idx;
   logic                   samp0, samp1, maj;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_bit, perr, ferr;
   logic                   push_req;
   logic [EW-1:0]          push_word;

   // Reset asserts immediately but is released only on a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
      end
   end

   assign maj       = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         line_q    <= 1'b1;
         samp0     <= 1'b0;
         samp1     <= 1'b0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
         push_req  <= 1'b0;
         push_word <= '0;
         o_break   <= 1'b0;
      end else begin
         push_req <= 1'b0;
         o_break  <= 1'b0;
         if (os_tick) begin
            line_q <= rx_sync;
            if (state != ST_IDLE && state != ST_RECOVER) begin
               cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
               if (cnt == SAMP0) samp0 <= rx_sync;
               if (cnt == SAMP1) samp1 <= rx_sync;
            end
            case (state)
               ST_IDLE: begin
                  if (line_q && !rx_sync) begin
                     state <= ST_START;
                     cnt   <= '0;
                     perr  <= 1'b0;
                     ferr  <= 1'b0;
                  end
               end
               ST_START: begin
                  if (cnt == SAMP2 && maj) begin
                     state <= ST_IDLE;
                  end else if (cnt == LAST) begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                  end
               end
               ST_DATA: begin
                  // LSB arrives first, so shifting right leaves it at bit 0.
                  if (cnt == SAMP2) shreg <= {maj, shreg[DATA_BITS-1:1]};
                  if (cnt == LAST) begin
                     if (bit_idx == BW'(DATA_BITS - 1)) begin
                        state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        stop_idx <= 1'b0;
                     end else begin
                        bit_idx <= bit_idx + BW'(1);
                     end
                  end
               end
               ST_PARITY: begin
                  if (cnt == SAMP2) begin
                     par_bit <= maj;
                     perr    <= (^shreg) ^ maj ^ (PARITY == 2);
                  end
                  if (cnt == LAST) begin
                     state    <= ST_STOP;
                     stop_idx <= 1'b0;
                  end
               end
               ST_STOP: begin
                  if (cnt == SAMP2) begin
                     if (!stop_idx && shreg == '0 && (PARITY == 0 || !par_bit) && !maj) begin
                        o_break <= 1'b1;
                        state   <= ST_RECOVER;
                     end else if (stop_idx == 1'(STOP_BITS - 1)) begin
                        push_req  <= 1'b1;
                        push_word <= {shreg, perr, ferr | ~maj};
                        state     <= rx_sync ? ST_IDLE : ST_RECOVER;
                     end else begin
                        ferr <= ferr | ~maj;
                     end
                  end else if (cnt == LAST) begin
                     stop_idx <= stop_idx + 1'(1);
                  end
               end
               ST_RECOVER: begin
                  if (rx_sync) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [AW:0]   count, count_next;
   logic          pop, full, accept;

   assign pop     = o_valid && o_ready;
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign accept  = push_req && (!full || pop);
   assign rd_next = rd_ptr + AW'(1);

   always_comb begin
      count_next = count;
      if (accept && !pop)      count_next = count + (AW+1)'(1);
      else if (!accept && pop) count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_next;
         count   <= count_next;
         o_valid <= (count_next != '0);
         // Head registers follow the entry that will sit at rd_ptr next cycle.
         if (pop) begin
            if (count > (AW+1)'(1))
               {o_data, o_parity_err, o_frame_err} <= mem[rd_next];
            else if (accept)
               {o_data, o_parity_err, o_frame_err} <= push_word;
         end else if (count == '0 && accept) begin
            {o_data, o_parity_err, o_frame_err} <= push_word;
         end
         if (push_req && full && !pop) o_overrun <= 1'b1;
         else if (i_clr_err)           o_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default instance and an even-parity/two-stop instance,
// each checked against a queue of frames predicted from the serial patterns sent.
module tb_uart_rx_fifo;

   localparam int OS   = 16;
   localparam int TDIV = 4;
   localparam int BIT  = OS * TDIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic os_tick = 1'b0;
   logic o_ready = 1'b1;
   logic ready_cmd = 1'b1;
   logic rand_ready = 1'b0;
   logic i_clr_err = 1'b0;
   logic rxd_d = 1'b1;
   logic rxd_x = 1'b1;
   int   div = 0;

   logic [7:0] data_d, data_x;
   logic       valid_d, perr_d, ferr_d, ovr_d, brk_d;
   logic       valid_x, perr_x, ferr_x, ovr_x, brk_x;
   logic [2:0] st_d, st_x;

   int         n_checks = 0;
   int         n_err = 0;
   logic [9:0] exp_q_d[$];
   logic [9:0] exp_q_x[$];
   logic       exp_ovr_d = 1'b0;
   int         brk_cnt_d = 0;
   int         brk_cnt_x = 0;

   uart_rx_fifo dut_d (
      .clk(clk), .rst(rst), .rxd(rxd_d), .os_tick(os_tick), .o_ready(o_ready),
      .i_clr_err(i_clr_err), .o_data(data_d), .o_valid(valid_d),
      .o_parity_err(perr_d), .o_frame_err(ferr_d), .o_overrun(ovr_d),
      .o_break(brk_d), .fsm_state(st_d)
   );

   uart_rx_fifo #(.PARITY(1), .STOP_BITS(2)) dut_x (
      .clk(clk), .rst(rst), .rxd(rxd_x), .os_tick(os_tick), .o_ready(o_ready),
      .i_clr_err(i_clr_err), .o_data(data_x), .o_valid(valid_x),
      .o_parity_err(perr_x), .o_frame_err(ferr_x), .o_overrun(ovr_x),
      .o_break(brk_x), .fsm_state(st_x)
   );

   // clock / strobe / ready generation
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      div     = (div + 1) % TDIV;
      os_tick = (div == 0);
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: every pop is compared with the oldest predicted entry
   always @(negedge clk) begin
      logic [9:0] e;
      if (brk_d) brk_cnt_d++;
      if (brk_x) brk_cnt_x++;
      if (valid_d && o_ready) begin
         if (exp_q_d.size() == 0) check("spurious_pop_d", 32'(valid_d), 0);
         else begin
            e = exp_q_d.pop_front();
            check("data_d", data_d, e[9:2]);
            check("perr_d", perr_d, e[1]);
            check("ferr_d", ferr_d, e[0]);
         end
      end
      if (valid_x && o_ready) begin
         if (exp_q_x.size() == 0) check("spurious_pop_x", 32'(valid_x), 0);
         else begin
            e = exp_q_x.pop_front();
            check("data_x", data_x, e[9:2]);
            check("perr_x", perr_x, e[1]);
            check("ferr_x", ferr_x, e[0]);
         end
      end
   end

   // driver tasks
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit which, input logic v);
      if (which) rxd_x = v;
      else       rxd_d = v;
   endtask

   task automatic send_frame(input bit which, input logic [7:0] data, input logic par,
                             input logic s1, input logic s2);
      set_line(which, 1'b0);
      wait_clks(BIT);
      for (int i = 0; i < 8; i++) begin
         set_line(which, data[i]);
         wait_clks(BIT);
      end
      if (which) begin
         set_line(which, par);
         wait_clks(BIT);
      end
      set_line(which, s1);
      wait_clks(BIT);
      if (which) begin
         set_line(which, s2);
         wait_clks(BIT);
      end
      set_line(which, 1'b1);
      wait_clks(2 * BIT);
   endtask

   // Model: even parity error if the count of ones in data+parity is odd;
   // framing error if any checked stop bit is low; drop when 4 entries wait.
   task automatic expect_frame(input bit which, input logic [7:0] data, input logic par,
                               input logic s1, input logic s2);
      logic perr, ferr;
      perr = which && (($countones(data) + int'(par)) % 2 == 1);
      ferr = !s1 || (which && !s2);
      if (which) begin
         if (exp_q_x.size() < 4) exp_q_x.push_back({data, perr, ferr});
      end else begin
         if (exp_q_d.size() < 4) exp_q_d.push_back({data, perr, ferr});
         else exp_ovr_d = 1'b1;
      end
      send_frame(which, data, par, s1, s2);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q_d.size() != 0 || exp_q_x.size() != 0) && n < 2000) begin
         wait_clks(1);
         n++;
      end
      wait_clks(4);
      check("drain_d", 32'(exp_q_d.size()), 0);
      check("drain_x", 32'(exp_q_x.size()), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       which, flip, s1, s2;

      wait_clks(5);
      check("rst_valid_d", valid_d, 0);
      check("rst_data_d", data_d, 0);
      check("rst_ovr_d", ovr_d, 0);
      check("rst_brk_d", brk_d, 0);
      check("rst_valid_x", valid_x, 0);
      check("rst_perr_x", perr_x, 0);
      check("rst_ferr_x", ferr_x, 0);
      rst = 1'b1;
      wait_clks(2 * BIT);

      // two clean frames, default format
      expect_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      expect_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);

      // wrong then correct even parity, then bad second stop bit
      expect_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
      expect_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      expect_frame(1, 8'hFF, 1'b0, 1'b1, 1'b0);

      // short low glitch on an idle line
      set_line(1, 1'b0);
      wait_clks(BIT * 3 / 10);
      set_line(1, 1'b1);
      wait_clks(3 * BIT);
      wait_drain();

      // overflow with the consumer stalled
      ready_cmd = 1'b0;
      wait_clks(4);
      for (int v = 1; v <= 5; v++) expect_frame(0, 8'(v), 1'b0, 1'b1, 1'b1);
      check("overrun_set", ovr_d, exp_ovr_d);
      check("full_valid", valid_d, exp_q_d.size() != 0);
      ready_cmd = 1'b1;
      wait_drain();
      check("overrun_sticky", ovr_d, exp_ovr_d);
      i_clr_err = 1'b1;
      wait_clks(1);
      i_clr_err = 1'b0;
      exp_ovr_d = 1'b0;
      wait_clks(2);
      check("overrun_clr", ovr_d, exp_ovr_d);

      // break: line low for 12 bit periods
      set_line(0, 1'b0);
      wait_clks(12 * BIT);
      check("break_pulses_low", brk_cnt_d, 1);
      check("break_no_push", valid_d, 0);
      set_line(0, 1'b1);
      wait_clks(2 * BIT);
      check("break_pulses_high", brk_cnt_d, 1);
      expect_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      wait_drain();

      // reset in data bit 4 of 0x81
      d = 8'h81;
      set_line(0, 1'b0);
      wait_clks(BIT);
      for (int i = 0; i < 4; i++) begin
         set_line(0, d[i]);
         wait_clks(BIT);
      end
      set_line(0, d[4]);
      wait_clks(BIT / 2);
      rst = 1'b0;
      wait_clks(3);
      check("midrst_valid_d", valid_d, 0);
      check("midrst_data_d", data_d, 0);
      check("midrst_data_x", data_x, 0);
      set_line(0, 1'b1);
      wait_clks(2 * BIT);
      rst = 1'b1;
      wait_clks(2 * BIT);
      expect_frame(0, 8'h42, 1'b0, 1'b1, 1'b1);
      wait_drain();

      // randomized frames with a randomly stalling consumer
      rand_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         which = 1'($urandom_range(0, 1));
         d     = 8'($urandom);
         flip  = ($urandom_range(0, 3) == 0);
         s1    = ($urandom_range(0, 3) != 0);
         s2    = ($urandom_range(0, 3) != 0);
         if (d == 8'h00) s1 = 1'b1;
         if (which) expect_frame(1, d, (^d) ^ flip, s1, s2);
         else       expect_frame(0, d, 1'b0, s1, 1'b1);
      end
      rand_ready = 1'b0;
      wait_drain();

      check("end_valid_d", valid_d, 0);
      check("end_valid_x", valid_x, 0);
      check("end_breaks_d", brk_cnt_d, 1);
      check("end_breaks_x", brk_cnt_x, 0);
      check("end_ovr_x", ovr_x, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
